// File: rtl/rect_draw_engine_pkg.sv
// rect_draw_engine_pkg: FSM encoding, screen defaults and palette shared by the drawing blocks
package rect_draw_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DRAW,
        S_NEXT,
        S_FINISH
    } state_e;

    localparam int DEF_SCREEN_W  = 160;
    localparam int DEF_SCREEN_H  = 120;
    localparam int DEF_BG_COLOUR = 0;

    localparam logic [2:0] COL_BLACK   = 3'd0;
    localparam logic [2:0] COL_BLUE    = 3'd1;
    localparam logic [2:0] COL_GREEN   = 3'd2;
    localparam logic [2:0] COL_CYAN    = 3'd3;
    localparam logic [2:0] COL_RED     = 3'd4;
    localparam logic [2:0] COL_MAGENTA = 3'd5;
    localparam logic [2:0] COL_YELLOW  = 3'd6;
    localparam logic [2:0] COL_WHITE   = 3'd7;

endpackage

// File: rtl/rect_raster_counter.sv
// rect_raster_counter: row-major walk over a rectangle with last-pixel and off-screen flags
module rect_raster_counter
    import rect_draw_engine_pkg::*;
#(
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_i,
    input  logic          adv_i,
    input  logic [XW-1:0] x0_i,
    input  logic [YW-1:0] y0_i,
    input  logic [XW-1:0] w_i,
    input  logic [YW-1:0] h_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o,
    output logic          clip_o
);

    localparam logic [XW:0] X1 = 1;
    localparam logic [YW:0] Y1 = 1;

    logic [XW-1:0] x0_q;
    logic [XW:0]   x_q, xe_q;
    logic [YW:0]   y_q, ye_q;

    // Positions and end points carry one extra bit so rectangles running off the screen edge never wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_q <= '0;
            x_q  <= '0;
            xe_q <= '0;
            y_q  <= '0;
            ye_q <= '0;
        end else if (load_i) begin
            x0_q <= x0_i;
            x_q  <= {1'b0, x0_i};
            y_q  <= {1'b0, y0_i};
            xe_q <= {1'b0, x0_i} + {1'b0, w_i} - X1;
            ye_q <= {1'b0, y0_i} + {1'b0, h_i} - Y1;
        end else if (adv_i) begin
            x_q <= (x_q == xe_q) ? {1'b0, x0_q} : x_q + X1;
            y_q <= (x_q == xe_q) ? y_q + Y1 : y_q;
        end
    end

    assign x_o    = x_q[XW-1:0];
    assign y_o    = y_q[YW-1:0];
    assign last_o = (x_q == xe_q) && (y_q == ye_q);
    assign clip_o = (x_q >= (XW+1)'(SCREEN_W)) || (y_q >= (YW+1)'(SCREEN_H));

endmodule

// File: rtl/rect_draw_engine.sv
// rect_draw_engine: rasterises up to N_RECT snapshotted rectangles into a ready/valid pixel stream
module rect_draw_engine
    import rect_draw_engine_pkg::*;
#(
    parameter int N_RECT    = 8,
    parameter int XW        = 8,
    parameter int YW        = 7,
    parameter int CW        = 3,
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int BG_COLOUR = DEF_BG_COLOUR
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [N_RECT-1:0]    erase,
    input  logic [N_RECT-1:0]    rect_en,
    input  logic [N_RECT*XW-1:0] rect_x,
    input  logic [N_RECT*YW-1:0] rect_y,
    input  logic [N_RECT*XW-1:0] rect_w,
    input  logic [N_RECT*YW-1:0] rect_h,
    input  logic [N_RECT*CW-1:0] rect_col,
    output logic [XW-1:0]        pix_x,
    output logic [YW-1:0]        pix_y,
    output logic [CW-1:0]        pix_col,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = (N_RECT > 1) ? $clog2(N_RECT) : 1;

    state_e               state_q;
    logic [IW-1:0]        idx_q;
    logic [N_RECT-1:0]    erase_q, en_q;
    logic [N_RECT*XW-1:0] x_q, w_q;
    logic [N_RECT*YW-1:0] y_q, h_q;
    logic [N_RECT*CW-1:0] col_q;
    logic [XW-1:0]        cur_x, cur_w, ld_x, ld_w, rc_x, pix_x_q;
    logic [YW-1:0]        cur_y, cur_h, ld_y, ld_h, rc_y, pix_y_q;
    logic [CW-1:0]        cur_col, pix_col_q;
    logic                 rc_last, rc_clip, free, load, adv;
    logic                 pix_valid_q, busy_q, done_q;

    assign cur_x   = x_q[idx_q*XW +: XW];
    assign cur_w   = w_q[idx_q*XW +: XW];
    assign cur_y   = y_q[idx_q*YW +: YW];
    assign cur_h   = h_q[idx_q*YW +: YW];
    assign cur_col = col_q[idx_q*CW +: CW];

    // The output slot can take a new pixel when empty or when its current pixel transfers this edge
    assign free = !pix_valid_q || pix_ready;
    assign load = (state_q == S_IDLE && start) || state_q == S_LOAD;
    assign adv  = (state_q == S_DRAW || state_q == S_CLEAR) && free;
    assign ld_x = (state_q == S_IDLE) ? '0 : cur_x;
    assign ld_y = (state_q == S_IDLE) ? '0 : cur_y;
    assign ld_w = (state_q == S_IDLE) ? XW'(SCREEN_W) : cur_w;
    assign ld_h = (state_q == S_IDLE) ? YW'(SCREEN_H) : cur_h;

    rect_raster_counter #(
        .XW       (XW),
        .YW       (YW),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (load),
        .adv_i   (adv),
        .x0_i    (ld_x),
        .y0_i    (ld_y),
        .w_i     (ld_w),
        .h_i     (ld_h),
        .x_o     (rc_x),
        .y_o     (rc_y),
        .last_o  (rc_last),
        .clip_o  (rc_clip)
    );

    // Capture the whole frame description on an accepted start so the pass ignores later input changes
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            erase_q <= erase;
            en_q    <= rect_en;
            x_q     <= rect_x;
            y_q     <= rect_y;
            w_q     <= rect_w;
            h_q     <= rect_h;
            col_q   <= rect_col;
        end
    end

    // Frame sequencing plus the registered pixel, busy and done outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_col_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (free) pix_valid_q <= 1'b0;
            if (adv) begin
                pix_valid_q <= !rc_clip;
                if (!rc_clip) begin
                    pix_x_q   <= rc_x;
                    pix_y_q   <= rc_y;
                    pix_col_q <= (state_q == S_DRAW && !erase_q[idx_q]) ? cur_col : CW'(BG_COLOUR);
                end
            end
            case (state_q)
                S_IDLE: if (start) begin
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= clear ? S_CLEAR : S_LOAD;
                end
                S_CLEAR: if (adv && rc_last) state_q <= S_LOAD;
                S_LOAD: state_q <= (en_q[idx_q] && cur_w != '0 && cur_h != '0) ? S_DRAW : S_NEXT;
                S_DRAW: if (adv && rc_last) state_q <= S_NEXT;
                S_NEXT: if (idx_q < IW'(N_RECT - 1)) begin
                    idx_q   <= idx_q + 1'b1;
                    state_q <= S_LOAD;
                end else if (free) begin
                    done_q  <= 1'b1;
                    state_q <= S_FINISH;
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_col   = pix_col_q;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rect_draw_engine.sv
// tb_rect_draw_engine: scoreboard bench for the rectangle rasteriser on a full and a tiny screen
module tb_rect_draw_engine;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic        clk, reset_n, start_a, start_b, clear, pix_ready, toggle;
    logic [1:0]  erase, rect_en;
    logic [15:0] rect_x, rect_w;
    logic [13:0] rect_y, rect_h;
    logic [5:0]  rect_col;
    logic [7:0]  px_a, px_b;
    logic [6:0]  py_a, py_b;
    logic [2:0]  pc_a, pc_b;
    logic        pv_a, pv_b, busy_a, busy_b, done_a, done_b;

    pix_t qa[$], qb[$];
    pix_t exp_a, exp_b;
    int   errors = 0, checks = 0, xfer_a = 0, xfer_b = 0, dn_a = 0, dn_b = 0, k = 0;
    logic        hold_a = 0, hold_b = 0;
    logic [18:0] held_a, held_b;
    logic [3:0]  pat = 4'b1001;

    rect_draw_engine #(.N_RECT(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .clear(clear), .erase(erase),
        .rect_en(rect_en), .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .rect_col(rect_col), .pix_x(px_a), .pix_y(py_a), .pix_col(pc_a), .pix_valid(pv_a),
        .pix_ready(pix_ready), .busy(busy_a), .done(done_a)
    );

    rect_draw_engine #(.N_RECT(2), .SCREEN_W(4), .SCREEN_H(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .clear(clear), .erase(erase),
        .rect_en(rect_en), .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .rect_col(rect_col), .pix_x(px_b), .pix_y(py_b), .pix_col(pc_b), .pix_valid(pv_b),
        .pix_ready(pix_ready), .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        pix_ready = 1;
        forever begin
            @(posedge clk);
            #2;
            if (toggle) begin
                pix_ready = pat[k % 4];
                k++;
            end else begin
                pix_ready = 1;
                k = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (done_a) dn_a++;
        if (hold_a) begin
            checks++;
            if ({pv_a, px_a, py_a, pc_a} !== held_a) begin
                errors++;
                $display("FAIL a_stall_hold got=%h want=%h", {pv_a, px_a, py_a, pc_a}, held_a);
            end
        end
        hold_a = pv_a && !pix_ready;
        held_a = {pv_a, px_a, py_a, pc_a};
        if (pv_a && pix_ready) begin
            xfer_a++;
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_pixel got=(%0d,%0d,%0d) want=none", px_a, py_a, pc_a);
            end else begin
                exp_a = qa.pop_front();
                if ({px_a, py_a, pc_a} !== exp_a) begin
                    errors++;
                    $display("FAIL a_pixel got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", px_a, py_a, pc_a, exp_a.x, exp_a.y, exp_a.c);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done_b) dn_b++;
        if (hold_b) begin
            checks++;
            if ({pv_b, px_b, py_b, pc_b} !== held_b) begin
                errors++;
                $display("FAIL b_stall_hold got=%h want=%h", {pv_b, px_b, py_b, pc_b}, held_b);
            end
        end
        hold_b = pv_b && !pix_ready;
        held_b = {pv_b, px_b, py_b, pc_b};
        if (pv_b && pix_ready) begin
            xfer_b++;
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_pixel got=(%0d,%0d,%0d) want=none", px_b, py_b, pc_b);
            end else begin
                exp_b = qb.pop_front();
                if ({px_b, py_b, pc_b} !== exp_b) begin
                    errors++;
                    $display("FAIL b_pixel got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", px_b, py_b, pc_b, exp_b.x, exp_b.y, exp_b.c);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic set_ch(input int i, input logic en, input int x, input int y, input int w, input int h, input int c, input logic e);
        rect_en[i]         = en;
        erase[i]           = e;
        rect_x[i*8 +: 8]   = 8'(x);
        rect_w[i*8 +: 8]   = 8'(w);
        rect_y[i*7 +: 7]   = 7'(y);
        rect_h[i*7 +: 7]   = 7'(h);
        rect_col[i*3 +: 3] = 3'(c);
    endtask

    task automatic ea(input int x, input int y, input int c);
        qa.push_back({8'(x), 7'(y), 3'(c)});
    endtask

    task automatic eb(input int x, input int y, input int c);
        qb.push_back({8'(x), 7'(y), 3'(c)});
    endtask

    task automatic go(input bit b);
        @(negedge clk);
        if (b) start_b = 1;
        else start_a = 1;
        @(posedge clk);
        #1;
        start_a = 0;
        start_b = 0;
    endtask

    task automatic wait_done(input bit b, input string name);
        int n = 0;
        while ((b ? dn_b : dn_a) == 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        chk({name, "_done_cnt"}, b ? dn_b : dn_a, 1);
        chk({name, "_left"}, b ? qb.size() : qa.size(), 0);
        dn_a = 0;
        dn_b = 0;
    endtask

    initial begin
        int x0, got;
        reset_n = 0; start_a = 0; start_b = 0; clear = 0; toggle = 0;
        erase = 0; rect_en = 0; rect_x = 0; rect_y = 0; rect_w = 0; rect_h = 0; rect_col = 0;
        #2;
        chk("rst_valid", pv_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_x", px_a, 0);
        chk("rst_y", py_a, 0);
        chk("rst_col", pc_a, 0);
        #20 reset_n = 1;
        // basic 3x2 rectangle, first pixel two edges after the start edge
        set_ch(0, 1, 20, 30, 3, 2, 3, 0);
        set_ch(1, 0, 0, 0, 5, 5, 7, 0);
        for (int y = 30; y < 32; y++) for (int x = 20; x < 23; x++) ea(x, y, 3);
        go(0);
        @(posedge clk); #1 chk("t1_lat_early", pv_a, 0);
        @(posedge clk); #1 chk("t1_lat_first", pv_a, 1);
        chk("t1_first_x", px_a, 20);
        wait_done(0, "t1");
        // same frame with stalls, plus input change and a restart attempt mid-pass
        toggle = 1;
        x0 = xfer_a;
        for (int y = 30; y < 32; y++) for (int x = 20; x < 23; x++) ea(x, y, 3);
        go(0);
        repeat (4) @(posedge clk);
        #1;
        rect_x[7:0] = 8'd50;
        start_a = 1;
        @(posedge clk);
        #1 start_a = 0;
        wait_done(0, "t2");
        chk("t2_xfers", xfer_a - x0, 6);
        toggle = 0;
        // clipping at the bottom-right corner
        set_ch(0, 1, 158, 118, 4, 4, 5, 0);
        ea(158, 118, 5); ea(159, 118, 5); ea(158, 119, 5); ea(159, 119, 5);
        go(0);
        wait_done(0, "t3");
        // two channels drawn in index order
        set_ch(0, 1, 5, 5, 1, 1, 1, 0);
        set_ch(1, 1, 6, 7, 2, 1, 2, 0);
        ea(5, 5, 1); ea(6, 7, 2); ea(7, 7, 2);
        go(0);
        wait_done(0, "t4");
        // empty rectangles: no pixels, done quickly
        set_ch(0, 1, 10, 10, 0, 2, 1, 0);
        set_ch(1, 1, 10, 10, 3, 0, 2, 0);
        x0 = xfer_a;
        go(0);
        got = 0;
        for (int i = 1; i <= 5 && got == 0; i++) begin
            @(posedge clk);
            #1 got = int'(done_a);
        end
        chk("t5_done_in_time", got, 1);
        repeat (3) @(posedge clk);
        dn_a = 0;
        chk("t5_xfers", xfer_a - x0, 0);
        // full clear on a 4x2 screen
        rect_en = 0;
        clear = 1;
        for (int y = 0; y < 2; y++) for (int x = 0; x < 4; x++) eb(x, y, 0);
        go(1);
        clear = 0;
        wait_done(1, "t6");
        // erased channel draws in background colour
        set_ch(0, 1, 1, 0, 2, 1, 6, 1);
        set_ch(1, 0, 0, 0, 1, 1, 7, 0);
        eb(1, 0, 0); eb(2, 0, 0);
        go(1);
        wait_done(1, "t7");
        // asynchronous reset during DRAW
        set_ch(0, 1, 20, 30, 3, 2, 3, 0);
        x0 = xfer_a;
        go(0);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("t8_valid_in_reset", pv_a, 0);
        chk("t8_busy_in_reset", busy_a, 0);
        qa.delete();
        #20 reset_n = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("t8_busy_after", busy_a, 0);
        chk("t8_done_after", dn_a, 0);
        chk("t8_xfers_after", xfer_a - x0, 0);
        chk("t8_x_after", px_a, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rect_draw_engine.md
RECT_DRAW_ENGINE -- requirements
Module: rect_draw_engine

Interface
REQ-001 Parameter N_RECT, default 8, number of rectangle channels, range 1..32.
REQ-002 Parameter XW, default 8, x coordinate/width bits.
REQ-003 Parameter YW, default 7, y coordinate/height bits.
REQ-004 Parameter CW, default 3, colour bits.
REQ-005 Parameters SCREEN_W, default 160, and SCREEN_H, default 120, visible area.
REQ-006 Parameter BG_COLOUR, default 0, erase/clear colour.
REQ-007 Port clk, input, 1, sole clock, rising edge.
REQ-008 Port reset_n, input, 1, asynchronous active-low reset.
REQ-009 Port start, input, 1, request one frame pass.
REQ-010 Port clear, input, 1, sampled with start; prepend full-screen BG_COLOUR fill.
REQ-011 Port erase, input, N_RECT, per channel; draw that rectangle in BG_COLOUR.
REQ-012 Port rect_en, input, N_RECT, per channel; 0 skips the channel.
REQ-013 Ports rect_x/rect_w, input, N_RECT*XW each; rect_y/rect_h, input, N_RECT*YW each; rect_col, input, N_RECT*CW; channel i in slice i.
REQ-014 Ports pix_x (XW), pix_y (YW), pix_col (CW), pix_valid (1), outputs; pix_ready, input, 1.
REQ-015 Ports busy, output, 1; done, output, 1-cycle pulse.

Function
REQ-016 FSM states IDLE, CLEAR, LOAD, DRAW, NEXT, FINISH; reset state IDLE.
REQ-017 IDLE: start=1 snapshots all rect_* inputs, erase and clear into internal registers; later input changes do not affect the pass.
REQ-018 start while busy=1 is ignored, not queued.
REQ-019 IDLE->CLEAR if clear sampled 1, else ->LOAD with channel index 0.
REQ-020 CLEAR emits every pixel (0,0)..(SCREEN_W-1,SCREEN_H-1), row-major, colour BG_COLOUR, then ->LOAD index 0.
REQ-021 LOAD: channel disabled or w=0 or h=0 -> NEXT without emitting; else counters at (x,y) -> DRAW.
REQ-022 DRAW emits pixels row-major: x from rect_x to rect_x+w-1, then y+1; w and h are pixel counts.
REQ-023 Emitted colour is BG_COLOUR if erase[i] else rect_col[i].
REQ-024 Coordinate sums computed at XW+1/YW+1 bits; pixels with x>=SCREEN_W or y>=SCREEN_H are clipped: pix_valid stays 0, counters still advance one per cycle.
REQ-025 Handshake: pixel transfers when pix_valid&pix_ready; while pix_valid=1 and pix_ready=0, pix_x/pix_y/pix_col/pix_valid hold stable and counters freeze.
REQ-026 pix_valid never drops without a completed transfer.
REQ-027 With pix_ready held 1, one visible pixel per cycle; first pixel of an unclipped channel 0 (no clear) valid 2 cycles after the start cycle.
REQ-028 Last pixel of a channel -> NEXT; NEXT increments index, ->LOAD if index<N_RECT-1, else ->FINISH.
REQ-029 FINISH asserts done for exactly one cycle, ->IDLE; start in that cycle is ignored.
REQ-030 busy=1 in every state except IDLE.
REQ-031 Channels drawn in ascending index; later channels overwrite earlier on the display.

Reset
REQ-032 reset_n=0 immediately forces IDLE, pix_valid=0, busy=0, done=0, pix_x=0, pix_y=0, pix_col=0, all counters and index 0, regardless of clock.
REQ-033 Reset mid-pass abandons the pass; no pixel or done follows deassertion without a new start.
REQ-034 Snapshot registers need no reset value.

Structure
REQ-035 Shared package holds the FSM state encoding, default SCREEN_W/SCREEN_H/BG_COLOUR and the colour constants used by game blocks.
REQ-036 One sub-module, rect_raster_counter: loads origin/size, steps row-major on advance, flags last pixel and clipped.
REQ-037 Channel mux, FSM and output register stage live in rect_draw_engine.

Verification
REQ-038 N_RECT=2, ch0 (20,30) w=3 h=2 col=3, ch1 disabled, ready=1, start -> 6 pixels (20..22,30),(20..22,31), col 3, first at start+2, done once after last.
REQ-039 Same, pix_ready toggling 1,0,0,1 -> outputs stable during stalls, exactly 6 transfers, no duplicates.
REQ-040 ch0 (158,118) w=4 h=4 -> only (158,118),(159,118),(158,119),(159,119) emitted.
REQ-041 clear=1, SCREEN_W=4, SCREEN_H=2, all disabled -> 8 pixels colour 0 then done; ch0 erase=1 col=6 -> its pixels colour 0.
REQ-042 ch0 w=0 and ch1 h=0 -> no pix_valid, done within N_RECT+3 cycles.
REQ-043 reset_n low during DRAW -> pix_valid/busy low same cycle; after release, no activity until start.
